// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial memory arbiter between instruction fetch and load/store unit
//
// Purpose: grants one of two requesters (fetch, LSU) access to a byte-wide
// RAM, then walks the access one byte per cycle. Reads assemble a
// little-endian, zero-extended word; writes emit bytes from the low end of the
// store data. Stores to IO_ADDR wait while the output FIFO is full.
//
// Ports:
//   clk_in, rst_in (async active-low), rdy_in (global freeze)
//   roll_back_flag            pipeline flush; aborts reads, never writes
//   ifetch_req/addr           fetch request, 4-byte read
//   ifetch_done/data          done pulse and fetched word (data holds)
//   lsu_req/rw/size/addr/wdata  load/store request
//   lsu_done/rdata            done pulse and load data (data holds)
//   mem_din/dout/a/wr         byte-wide RAM port
//   io_buffer_full            output FIFO full, stalls IO stores

module mem_arbiter #(
    parameter logic [31:0] IO_ADDR = 32'h30000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        roll_back_flag,
    input  logic        ifetch_req,
    input  logic [31:0] ifetch_addr,
    output logic        ifetch_done,
    output logic [31:0] ifetch_data,
    input  logic        lsu_req,
    input  logic        lsu_rw,
    input  logic [1:0]  lsu_size,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        WAIT_IO,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  nbytes_q, nbytes_d;
    logic        last_lsu_q, last_lsu_d;   // 1 = LSU was granted last
    logic        own_lsu_q, own_lsu_d;     // owner of the access in flight
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;

    logic        ifetch_done_q, ifetch_done_d;
    logic [31:0] ifetch_data_q, ifetch_data_d;
    logic        lsu_done_q, lsu_done_d;
    logic [31:0] lsu_rdata_q, lsu_rdata_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic        mem_wr_q, mem_wr_d;

    logic        pick_lsu;
    logic [2:0]  lsu_n;
    logic [2:0]  cnt_nx;

    assign ifetch_done = ifetch_done_q;
    assign ifetch_data = ifetch_data_q;
    assign lsu_done    = lsu_done_q;
    assign lsu_rdata   = lsu_rdata_q;
    assign mem_dout    = mem_dout_q;
    assign mem_a       = mem_a_q;
    assign mem_wr      = mem_wr_q;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_sel = w[7:0];
            2'd1:    byte_sel = w[15:8];
            2'd2:    byte_sel = w[23:16];
            default: byte_sel = w[31:24];
        endcase
    endfunction

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        nbytes_d      = nbytes_q;
        last_lsu_d    = last_lsu_q;
        own_lsu_d     = own_lsu_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rbuf_d        = rbuf_q;
        ifetch_data_d = ifetch_data_q;
        lsu_rdata_d   = lsu_rdata_q;
        // Pulses and the RAM port fall back to 0 unless a state drives them.
        ifetch_done_d = 1'b0;
        lsu_done_d    = 1'b0;
        mem_a_d       = 32'd0;
        mem_dout_d    = 8'd0;
        mem_wr_d      = 1'b0;

        cnt_nx   = cnt_q + 3'd1;
        // On a tie the side not granted last time wins.
        pick_lsu = lsu_req && (!ifetch_req || !last_lsu_q);
        case (lsu_size)
            2'd0:    lsu_n = 3'd1;
            2'd1:    lsu_n = 3'd2;
            default: lsu_n = 3'd4;
        endcase

        case (state_q)
            IDLE: begin
                if (!roll_back_flag && (ifetch_req || lsu_req)) begin
                    last_lsu_d = pick_lsu;
                    own_lsu_d  = pick_lsu;
                    cnt_d      = 3'd0;
                    rbuf_d     = 32'd0;
                    if (pick_lsu) begin
                        addr_d   = lsu_addr;
                        wdata_d  = lsu_wdata;
                        nbytes_d = lsu_n;
                        if (lsu_rw) begin
                            if (lsu_addr == IO_ADDR && io_buffer_full) begin
                                state_d = WAIT_IO;
                            end else begin
                                state_d    = WRITE;
                                mem_a_d    = lsu_addr;
                                mem_dout_d = lsu_wdata[7:0];
                                mem_wr_d   = 1'b1;
                            end
                        end else begin
                            state_d = READ;
                            mem_a_d = lsu_addr;
                        end
                    end else begin
                        addr_d   = ifetch_addr;
                        nbytes_d = 3'd4;
                        state_d  = READ;
                        mem_a_d  = ifetch_addr;
                    end
                end
            end

            READ: begin
                if (roll_back_flag) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    // RAM returns a byte one cycle after its address, so the
                    // byte arriving now belongs to address index cnt_q-1.
                    case (cnt_q)
                        3'd1:    rbuf_d[7:0]   = mem_din;
                        3'd2:    rbuf_d[15:8]  = mem_din;
                        3'd3:    rbuf_d[23:16] = mem_din;
                        3'd4:    rbuf_d[31:24] = mem_din;
                        default: ;
                    endcase
                    if (cnt_q == nbytes_q) begin
                        state_d = DONE;
                        cnt_d   = 3'd0;
                        if (own_lsu_q) begin
                            lsu_rdata_d = rbuf_d;
                            lsu_done_d  = 1'b1;
                        end else begin
                            ifetch_data_d = rbuf_d;
                            ifetch_done_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_nx;
                        if (cnt_nx < nbytes_q) begin
                            mem_a_d = addr_q + {29'd0, cnt_nx};
                        end
                    end
                end
            end

            WRITE: begin
                // Writes ignore roll_back_flag: a committed store always lands.
                if (cnt_q == nbytes_q - 3'd1) begin
                    state_d    = DONE;
                    cnt_d      = 3'd0;
                    lsu_done_d = 1'b1;
                end else begin
                    cnt_d      = cnt_nx;
                    mem_a_d    = addr_q + {29'd0, cnt_nx};
                    mem_dout_d = byte_sel(wdata_q, cnt_nx[1:0]);
                    mem_wr_d   = 1'b1;
                end
            end

            WAIT_IO: begin
                if (!io_buffer_full) begin
                    state_d    = WRITE;
                    cnt_d      = 3'd0;
                    mem_a_d    = addr_q;
                    mem_dout_d = wdata_q[7:0];
                    mem_wr_d   = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= IDLE;
            cnt_q         <= 3'd0;
            nbytes_q      <= 3'd0;
            last_lsu_q    <= 1'b1;
            own_lsu_q     <= 1'b0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            rbuf_q        <= 32'd0;
            ifetch_done_q <= 1'b0;
            ifetch_data_q <= 32'd0;
            lsu_done_q    <= 1'b0;
            lsu_rdata_q   <= 32'd0;
            mem_dout_q    <= 8'd0;
            mem_a_q       <= 32'd0;
            mem_wr_q      <= 1'b0;
        end else if (rdy_in) begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            nbytes_q      <= nbytes_d;
            last_lsu_q    <= last_lsu_d;
            own_lsu_q     <= own_lsu_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rbuf_q        <= rbuf_d;
            ifetch_done_q <= ifetch_done_d;
            ifetch_data_q <= ifetch_data_d;
            lsu_done_q    <= lsu_done_d;
            lsu_rdata_q   <= lsu_rdata_d;
            mem_dout_q    <= mem_dout_d;
            mem_a_q       <= mem_a_d;
            mem_wr_q      <= mem_wr_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        roll_back_flag;
    logic        ifetch_req;
    logic [31:0] ifetch_addr;
    logic        ifetch_done;
    logic [31:0] ifetch_data;
    logic        lsu_req;
    logic        lsu_rw;
    logic [1:0]  lsu_size;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int checks;
    int errors;

    mem_arbiter #(.IO_ADDR(32'h30000)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .roll_back_flag(roll_back_flag),
        .ifetch_req(ifetch_req),
        .ifetch_addr(ifetch_addr),
        .ifetch_done(ifetch_done),
        .ifetch_data(ifetch_data),
        .lsu_req(lsu_req),
        .lsu_rw(lsu_rw),
        .lsu_size(lsu_size),
        .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata),
        .lsu_done(lsu_done),
        .lsu_rdata(lsu_rdata),
        .mem_din(mem_din),
        .mem_dout(mem_dout),
        .mem_a(mem_a),
        .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h1000: rom = 8'h13;
            32'h1001: rom = 8'h00;
            32'h1002: rom = 8'h00;
            32'h1003: rom = 8'h93;
            32'h1004: rom = 8'h37;
            32'h1005: rom = 8'h41;
            32'h1006: rom = 8'h00;
            32'h1007: rom = 8'h00;
            32'h2000: rom = 8'hEF;
            32'h2001: rom = 8'hBE;
            32'h2002: rom = 8'hAD;
            32'h2003: rom = 8'hDE;
            32'h30000: rom = 8'h5A;
            32'hFFFFFFFE: rom = 8'h11;
            32'hFFFFFFFF: rom = 8'h22;
            32'h0: rom = 8'h33;
            32'h1: rom = 8'h44;
            default: rom = 8'h00;
        endcase
    endfunction

    // One-cycle read latency RAM model.
    always @(posedge clk_in) mem_din <= rom(mem_a);

    task automatic do_reset;
        rst_in = 1'b0;
        rdy_in = 1'b1;
        roll_back_flag = 1'b0;
        ifetch_req = 1'b0;
        ifetch_addr = 32'd0;
        lsu_req = 1'b0;
        lsu_rw = 1'b0;
        lsu_size = 2'd0;
        lsu_addr = 32'd0;
        lsu_wdata = 32'd0;
        io_buffer_full = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        rst_in = 1'b0;
        ifetch_req = 1'b1;
        ifetch_addr = 32'h1000;
        repeat (3) @(negedge clk_in);
        checks++;
        if (mem_a !== 32'd0 || mem_dout !== 8'd0 || mem_wr !== 1'b0 || ifetch_done !== 1'b0 ||
            lsu_done !== 1'b0 || ifetch_data !== 32'd0 || lsu_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs mem_a=%h dout=%h wr=%b idone=%b ldone=%b idata=%h ldata=%h expected all 0",
                     mem_a, mem_dout, mem_wr, ifetch_done, lsu_done, ifetch_data, lsu_rdata);
        end
        rst_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if (mem_a !== 32'h1000 || mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL first_grant mem_a=%h wr=%b expected 00001000/0", mem_a, mem_wr);
        end
        rst_in = 1'b0;
        ifetch_req = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_in);
            checks++;
            if (ifetch_done !== 1'b0 || mem_a !== 32'd0) begin
                errors++;
                $display("FAIL abandoned_fetch c=%0d idone=%b mem_a=%h expected 0/0", c, ifetch_done, mem_a);
            end
        end
    endtask

    task automatic test_fetch;
        do_reset();
        ifetch_req = 1'b1;
        ifetch_addr = 32'h1000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            checks++;
            if (mem_a !== 32'h1000 + 32'(k) || mem_wr !== 1'b0) begin
                errors++;
                $display("FAIL fetch_addr k=%0d mem_a=%h wr=%b expected %h/0", k, mem_a, mem_wr, 32'h1000 + 32'(k));
            end
        end
        @(negedge clk_in);
        checks++;
        if (ifetch_done !== 1'b0) begin
            errors++;
            $display("FAIL fetch_early_done idone=%b expected 0", ifetch_done);
        end
        @(negedge clk_in);
        checks++;
        if (ifetch_done !== 1'b1 || ifetch_data !== 32'h93000013) begin
            errors++;
            $display("FAIL fetch_done idone=%b data=%h expected 1/93000013", ifetch_done, ifetch_data);
        end
        ifetch_req = 1'b0;
        @(negedge clk_in);
        checks++;
        if (ifetch_done !== 1'b0 || ifetch_data !== 32'h93000013 || mem_a !== 32'd0) begin
            errors++;
            $display("FAIL fetch_hold idone=%b data=%h mem_a=%h expected 0/93000013/0", ifetch_done, ifetch_data, mem_a);
        end
    endtask

    task automatic test_tie;
        do_reset();
        ifetch_req = 1'b1;
        ifetch_addr = 32'h1000;
        lsu_req = 1'b1;
        lsu_rw = 1'b0;
        lsu_size = 2'd2;
        lsu_addr = 32'h2000;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk_in);
            checks++;
            if (mem_wr !== 1'b0) begin
                errors++;
                $display("FAIL tie_no_write c=%0d wr=%b expected 0", c, mem_wr);
            end
            if (c == 8) begin
                checks++;
                if (mem_a !== 32'h2000) begin
                    errors++;
                    $display("FAIL tie_lsu_wins c=%0d mem_a=%h expected 00002000", c, mem_a);
                end
            end
            if (c == 6) begin
                checks++;
                if (ifetch_done !== 1'b1 || ifetch_data !== 32'h93000013 || lsu_done !== 1'b0) begin
                    errors++;
                    $display("FAIL tie_fetch_first idone=%b data=%h ldone=%b expected 1/93000013/0",
                             ifetch_done, ifetch_data, lsu_done);
                end
                ifetch_addr = 32'h1004;
            end
            if (c == 13) begin
                checks++;
                if (lsu_done !== 1'b1 || lsu_rdata !== 32'hDEADBEEF || ifetch_done !== 1'b0) begin
                    errors++;
                    $display("FAIL tie_lsu_second ldone=%b rdata=%h idone=%b expected 1/deadbeef/0",
                             lsu_done, lsu_rdata, ifetch_done);
                end
                lsu_req = 1'b0;
            end
            if (c == 20) begin
                checks++;
                if (ifetch_done !== 1'b1 || ifetch_data !== 32'h00004137) begin
                    errors++;
                    $display("FAIL tie_fetch_third idone=%b data=%h expected 1/00004137", ifetch_done, ifetch_data);
                end
                ifetch_req = 1'b0;
            end
        end
        @(negedge clk_in);
    endtask

    task automatic test_lsu_sizes;
        logic [31:0] ta [0:5];
        logic [1:0]  ts [0:5];
        logic [31:0] te [0:5];
        int          tn [0:5];
        ta[0] = 32'h2001;     ts[0] = 2'd0; te[0] = 32'h000000BE; tn[0] = 1;
        ta[1] = 32'h2002;     ts[1] = 2'd1; te[1] = 32'h0000DEAD; tn[1] = 2;
        ta[2] = 32'h2000;     ts[2] = 2'd3; te[2] = 32'hDEADBEEF; tn[2] = 4;
        ta[3] = 32'h2003;     ts[3] = 2'd0; te[3] = 32'h000000DE; tn[3] = 1;
        ta[4] = 32'h30000;    ts[4] = 2'd0; te[4] = 32'h0000005A; tn[4] = 1;
        ta[5] = 32'hFFFFFFFE; ts[5] = 2'd2; te[5] = 32'h44332211; tn[5] = 4;
        do_reset();
        io_buffer_full = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lsu_req = 1'b1;
            lsu_rw = 1'b0;
            lsu_size = ts[i];
            lsu_addr = ta[i];
            for (int c = 1; c <= tn[i] + 2; c++) begin
                @(negedge clk_in);
                if (c <= tn[i]) begin
                    checks++;
                    if (mem_a !== ta[i] + 32'(c - 1) || mem_wr !== 1'b0) begin
                        errors++;
                        $display("FAIL size_addr i=%0d c=%0d mem_a=%h wr=%b expected %h/0",
                                 i, c, mem_a, mem_wr, ta[i] + 32'(c - 1));
                    end
                end
                if (c == tn[i] + 2) begin
                    checks++;
                    if (lsu_done !== 1'b1 || lsu_rdata !== te[i]) begin
                        errors++;
                        $display("FAIL size_done i=%0d ldone=%b rdata=%h expected 1/%h", i, lsu_done, lsu_rdata, te[i]);
                    end
                    lsu_req = 1'b0;
                end else begin
                    checks++;
                    if (lsu_done !== 1'b0) begin
                        errors++;
                        $display("FAIL size_early_done i=%0d c=%0d ldone=%b expected 0", i, c, lsu_done);
                    end
                end
            end
            @(negedge clk_in);
            checks++;
            if (lsu_done !== 1'b0 || lsu_rdata !== te[i]) begin
                errors++;
                $display("FAIL size_hold i=%0d ldone=%b rdata=%h expected 0/%h", i, lsu_done, lsu_rdata, te[i]);
            end
        end
        io_buffer_full = 1'b0;
    endtask

    task automatic test_io_stall;
        do_reset();
        io_buffer_full = 1'b1;
        lsu_req = 1'b1;
        lsu_rw = 1'b1;
        lsu_size = 2'd0;
        lsu_addr = 32'h30000;
        lsu_wdata = 32'hFFFFFF41;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_in);
            checks++;
            if (c <= 3) begin
                if (mem_wr !== 1'b0 || mem_a !== 32'd0 || lsu_done !== 1'b0) begin
                    errors++;
                    $display("FAIL io_wait c=%0d wr=%b mem_a=%h ldone=%b expected 0/0/0", c, mem_wr, mem_a, lsu_done);
                end
                if (c == 1) roll_back_flag = 1'b1;
                if (c == 2) roll_back_flag = 1'b0;
                if (c == 3) io_buffer_full = 1'b0;
            end else if (c == 4) begin
                if (mem_wr !== 1'b1 || mem_dout !== 8'h41 || mem_a !== 32'h30000 || lsu_done !== 1'b0) begin
                    errors++;
                    $display("FAIL io_write wr=%b dout=%h mem_a=%h ldone=%b expected 1/41/00030000/0",
                             mem_wr, mem_dout, mem_a, lsu_done);
                end
            end else begin
                if (lsu_done !== 1'b1 || mem_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL io_done ldone=%b wr=%b expected 1/0", lsu_done, mem_wr);
                end
                lsu_req = 1'b0;
            end
        end
        @(negedge clk_in);
    endtask

    task automatic test_rollback;
        logic [31:0] wd;
        do_reset();
        lsu_req = 1'b1;
        lsu_rw = 1'b0;
        lsu_size = 2'd0;
        lsu_addr = 32'h2001;
        @(negedge clk_in);
        checks++;
        if (mem_a !== 32'h2001 || mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL rb_lb_addr mem_a=%h wr=%b expected 00002001/0", mem_a, mem_wr);
        end
        roll_back_flag = 1'b1;
        lsu_req = 1'b0;
        @(negedge clk_in);
        checks++;
        if (mem_a !== 32'd0 || mem_wr !== 1'b0 || lsu_done !== 1'b0) begin
            errors++;
            $display("FAIL rb_lb_flush mem_a=%h wr=%b ldone=%b expected 0/0/0", mem_a, mem_wr, lsu_done);
        end
        roll_back_flag = 1'b0;
        lsu_req = 1'b1;
        lsu_addr = 32'h2002;
        @(negedge clk_in);
        checks++;
        if (mem_a !== 32'h2002 || lsu_done !== 1'b0) begin
            errors++;
            $display("FAIL rb_idle_regrant mem_a=%h ldone=%b expected 00002002/0", mem_a, lsu_done);
        end
        @(negedge clk_in);
        checks++;
        if (lsu_done !== 1'b0) begin
            errors++;
            $display("FAIL rb_no_done ldone=%b expected 0", lsu_done);
        end
        @(negedge clk_in);
        checks++;
        if (lsu_done !== 1'b1 || lsu_rdata !== 32'h000000AD) begin
            errors++;
            $display("FAIL rb_regrant_done ldone=%b rdata=%h expected 1/000000ad", lsu_done, lsu_rdata);
        end
        lsu_req = 1'b0;
        @(negedge clk_in);

        wd = 32'hAABBCCDD;
        lsu_req = 1'b1;
        lsu_rw = 1'b1;
        lsu_size = 2'd2;
        lsu_addr = 32'h2000;
        lsu_wdata = wd;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_in);
            checks++;
            if (c <= 4) begin
                if (mem_a !== 32'h2000 + 32'(c - 1) || mem_dout !== wd[8*(c-1) +: 8] ||
                    mem_wr !== 1'b1 || lsu_done !== 1'b0) begin
                    errors++;
                    $display("FAIL rb_sw_byte c=%0d mem_a=%h dout=%h wr=%b ldone=%b expected %h/%h/1/0",
                             c, mem_a, mem_dout, mem_wr, lsu_done, 32'h2000 + 32'(c - 1), wd[8*(c-1) +: 8]);
                end
                if (c == 2) roll_back_flag = 1'b1;
                if (c == 3) roll_back_flag = 1'b0;
            end else begin
                if (lsu_done !== 1'b1 || mem_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL rb_sw_done ldone=%b wr=%b expected 1/0", lsu_done, mem_wr);
                end
                lsu_req = 1'b0;
            end
        end
        @(negedge clk_in);
    endtask

    task automatic test_reset_mid_write;
        do_reset();
        lsu_req = 1'b1;
        lsu_rw = 1'b1;
        lsu_size = 2'd2;
        lsu_addr = 32'h2000;
        lsu_wdata = 32'h11223344;
        @(negedge clk_in);
        checks++;
        if (mem_wr !== 1'b1 || mem_dout !== 8'h44) begin
            errors++;
            $display("FAIL rst_sw_start wr=%b dout=%h expected 1/44", mem_wr, mem_dout);
        end
        @(negedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        checks++;
        if (mem_wr !== 1'b0 || mem_a !== 32'd0 || mem_dout !== 8'd0) begin
            errors++;
            $display("FAIL rst_async wr=%b mem_a=%h dout=%h expected 0/0/0", mem_wr, mem_a, mem_dout);
        end
        lsu_req = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_in);
            checks++;
            if (lsu_done !== 1'b0 || mem_wr !== 1'b0) begin
                errors++;
                $display("FAIL rst_abandon c=%0d ldone=%b wr=%b expected 0/0", c, lsu_done, mem_wr);
            end
        end
    endtask

    task automatic test_rdy_freeze;
        do_reset();
        lsu_req = 1'b1;
        lsu_rw = 1'b0;
        lsu_size = 2'd1;
        lsu_addr = 32'h2002;
        @(negedge clk_in);
        checks++;
        if (mem_a !== 32'h2002) begin
            errors++;
            $display("FAIL rdy_a1 mem_a=%h expected 00002002", mem_a);
        end
        rdy_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if (mem_a !== 32'h2002) begin
            errors++;
            $display("FAIL rdy_hold1 mem_a=%h expected 00002002", mem_a);
        end
        roll_back_flag = 1'b1;
        @(negedge clk_in);
        checks++;
        if (mem_a !== 32'h2002 || lsu_done !== 1'b0) begin
            errors++;
            $display("FAIL rdy_hold2 mem_a=%h ldone=%b expected 00002002/0", mem_a, lsu_done);
        end
        rdy_in = 1'b1;
        roll_back_flag = 1'b0;
        @(negedge clk_in);
        checks++;
        if (mem_a !== 32'h2003 || lsu_done !== 1'b0) begin
            errors++;
            $display("FAIL rdy_resume mem_a=%h ldone=%b expected 00002003/0", mem_a, lsu_done);
        end
        @(negedge clk_in);
        checks++;
        if (lsu_done !== 1'b0) begin
            errors++;
            $display("FAIL rdy_early_done ldone=%b expected 0", lsu_done);
        end
        @(negedge clk_in);
        checks++;
        if (lsu_done !== 1'b1 || lsu_rdata !== 32'h0000DEAD) begin
            errors++;
            $display("FAIL rdy_done ldone=%b rdata=%h expected 1/0000dead", lsu_done, lsu_rdata);
        end
        lsu_req = 1'b0;
        @(negedge clk_in);
        checks++;
        if (lsu_done !== 1'b0) begin
            errors++;
            $display("FAIL rdy_pulse ldone=%b expected 0", lsu_done);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_in = 1'b0;
        rdy_in = 1'b1;
        roll_back_flag = 1'b0;
        ifetch_req = 1'b0;
        ifetch_addr = 32'd0;
        lsu_req = 1'b0;
        lsu_rw = 1'b0;
        lsu_size = 2'd0;
        lsu_addr = 32'd0;
        lsu_wdata = 32'd0;
        io_buffer_full = 1'b0;
        test_reset();
        test_fetch();
        test_tie();
        test_lsu_sizes();
        test_io_stall();
        test_rollback();
        test_reset_mid_write();
        test_rdy_freeze();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
